// File: rtl/k580_pkg.sv
// Shared types and constants for the K580 interrupt-acknowledge master.
// State encoding, CALL opcode and timer load helper.
package k580_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_GAP,
        ST_DONE
    } k580_state_e;

    localparam logic [7:0] K580_OP_CALL  = 8'hCD;
    localparam logic [1:0] K580_LAST_IDX = 2'd2;

    // Timer expires when its count reaches zero, so a W-cycle phase loads W-1.
    function automatic logic [3:0] k580_ld(input int unsigned w);
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/k580_inta_tmr.sv
// Phase timer for the LOW/GAP intervals of the acknowledge sequence.
// Loads a value, counts down to zero and flags expiry while at zero.
module k580_inta_tmr (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/k580_inta_master.sv
// 8080-style INTA master: three acknowledge pulses, CALL vector capture.
// Define K580_INTA_OPCHK_EN to flag a first byte that is not CALL.
module k580_inta_master
    import k580_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        intr,
    input  logic        inte,
    input  logic        take,
    input  logic [7:0]  pic_data,
    output logic        inta_n,
    output logic        busy,
    output logic        inte_clr,
    output logic [15:0] vector,
    output logic        vec_valid,
    output logic        vec_err
);

    localparam logic [3:0] PULSE_LD = k580_ld(PULSE_W);
    localparam logic [3:0] GAP_LD   = k580_ld(GAP_W);

    k580_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte_q [3];
    logic [7:0]  byte_d [3];
    logic [15:0] vector_q, vector_d;
    logic        inta_n_q, inta_n_d;
    logic        inte_clr_q, inte_clr_d;
    logic        vec_valid_q, vec_valid_d;
    logic        vec_err_q, vec_err_d;
    logic        tmr_load;
    logic [3:0]  tmr_val;
    logic        tmr_exp;
    logic        enter_done;

    k580_inta_tmr u_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        vector_d = vector_q;
        tmr_load = 1'b0;
        tmr_val  = PULSE_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (take && intr && inte) begin
                    state_d  = ST_LOW;
                    idx_d    = 2'd0;
                    tmr_load = 1'b1;
                end
            end
            ST_LOW: begin
                if (tmr_exp) begin
                    byte_d[idx_q] = pic_data;
                    if (idx_q == K580_LAST_IDX) begin
                        state_d  = ST_DONE;
                        // byte2 arrives on this very edge
                        vector_d = {pic_data, byte_q[1]};
                    end else begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_exp) begin
                    state_d  = ST_LOW;
                    idx_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        inta_n_d   = (state_d != ST_LOW);
        inte_clr_d = (state_q == ST_IDLE) && (state_d == ST_LOW);
        enter_done = (state_d == ST_DONE);
`ifdef K580_INTA_OPCHK_EN
        vec_valid_d = enter_done && (byte_q[0] == K580_OP_CALL);
        vec_err_d   = enter_done && (byte_q[0] != K580_OP_CALL);
`else
        vec_valid_d = enter_done;
        vec_err_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            byte_q      <= '{default: 8'h00};
            vector_q    <= 16'h0000;
            inta_n_q    <= 1'b1;
            inte_clr_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            vector_q    <= vector_d;
            inta_n_q    <= inta_n_d;
            inte_clr_q  <= inte_clr_d;
            vec_valid_q <= vec_valid_d;
            vec_err_q   <= vec_err_d;
        end
    end

    assign inta_n    = inta_n_q;
    assign busy      = (state_q != ST_IDLE);
    assign inte_clr  = inte_clr_q;
    assign vector    = vector_q;
    assign vec_valid = vec_valid_q;
    assign vec_err   = vec_err_q;

endmodule

// File: doc/k580_inta_master.md
K580_INTA_MASTER -- requirements
Module: k580_inta_master

Interface
REQ-001 Parameter PULSE_W, default 2, cycles inta_n is held low per pulse (legal 1..15).
REQ-002 Parameter GAP_W, default 1, cycles inta_n is held high between pulses (legal 1..15).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 intr  input  1  interrupt request from the interrupt controller.
REQ-006 inte  input  1  CPU interrupt-enable flag.
REQ-007 take  input  1  CPU instruction-boundary strobe; acceptance opportunity.
REQ-008 pic_data  input  8  controller read-data bus, valid while inta_n low.
REQ-009 inta_n  output  1  interrupt-acknowledge strobe to the controller, active low.
REQ-010 busy  output  1  acknowledge sequence in progress.
REQ-011 inte_clr  output  1  one-cycle pulse; CPU clears INTE.
REQ-012 vector  output  16  call target {byte2,byte1}, held until next completion.
REQ-013 vec_valid  output  1  one-cycle pulse; vector updated.
REQ-014 vec_err  output  1  one-cycle pulse; opcode byte was not 8'hCD (see Configuration).

Function
REQ-015 States: IDLE, LOW, GAP, DONE; 2-bit pulse index idx (0..2); 4-bit cycle counter cnt.
REQ-016 IDLE: when take & intr & inte are sampled high in cycle T, the block shall enter LOW with idx=0 and cnt=0; inte_clr=1 in cycle T+1.
REQ-017 LOW: inta_n=0 for exactly PULSE_W cycles; on the clock edge ending the last low cycle, pic_data shall be captured into byte[idx].
REQ-018 After LOW with idx<2: GAP, inta_n=1 for exactly GAP_W cycles, then LOW with idx+1.
REQ-019 After LOW with idx=2: DONE for one cycle, inta_n=1, vector={byte2,byte1}, vec_valid=1 (or vec_err=1), then IDLE.
REQ-020 Defaults PULSE_W=2, GAP_W=1: low T+1..T+2, T+4..T+5, T+7..T+8; DONE at T+9; total 3*PULSE_W+2*GAP_W+1 cycles.
REQ-021 busy=1 in every non-IDLE cycle; busy=0 in IDLE.
REQ-022 take, intr and inte shall be ignored while busy; intr deassertion mid-sequence shall not shorten it (always exactly three pulses).
REQ-023 take asserted in the cycle DONE is active shall not start a new sequence; the earliest restart is sampled in the first IDLE cycle.
REQ-024 inta_n shall be glitch-free: driven directly from a register.

Reset
REQ-025 reset_n low at a clock edge: state=IDLE, inta_n=1, busy=0, inte_clr=0, vec_valid=0, vec_err=0, vector=16'h0000, bytes cleared; applies mid-sequence with no completion pulse.

Configuration
REQ-026 Macro K580_INTA_OPCHK_EN defined: in DONE, if byte0!=8'hCD, vec_err=1 and vec_valid=0 (vector still updated); otherwise vec_valid=1.
REQ-027 Macro K580_INTA_OPCHK_EN undefined: byte0 not compared, vec_valid=1 in every DONE, vec_err tied 0.

Structure
REQ-028 Shared package k580_pkg shall hold the state enum type and constant K580_OP_CALL=8'hCD.
REQ-029 One sub-module k580_inta_tmr (load value, down-count, expire flag) is natural for the LOW/GAP timing; the FSM stays in k580_inta_master.

Verification
REQ-030 Defaults; controller model returns CD,34,12; take&intr&inte in cycle 0 -> inta_n low cycles 1-2,4-5,7-8; vector=16'h1234, vec_valid at cycle 9; inte_clr at cycle 1.
REQ-031 inte=0 with intr=1, take pulsed -> inta_n stays 1, busy 0, no pulses.
REQ-032 intr dropped at cycle 3 -> three full pulses still issued, vec_valid at cycle 9.
REQ-033 OPCHK_EN defined, byte0=8'hFF, bytes 00,80 -> vec_err=1, vec_valid=0, vector=16'h8000; undefined -> vec_valid=1.
REQ-034 reset_n low at cycle 5 -> inta_n=1 next cycle, busy=0, no vec_valid; new take after release restarts from idx 0.
REQ-035 PULSE_W=1, GAP_W=3 -> low cycles 1,5,9; DONE at cycle 10.
